// File: rtl/pd0_pkg.sv
// rtl/pd0_pkg.sv - shared width and ALU operation encoding for pd0
package pd0_pkg;

    localparam int DWIDTH = 32;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        AND = 2'b10,
        OR  = 2'b11
    } alu_sel_t;

endpackage

// File: rtl/pd0.sv
// rtl/pd0.sv - four independent probe-driven functions: xor, alu, register, pipelined adder
//   clk_i  : rising-edge clock
//   rst_ni : asynchronous active-low reset for the register and the pipeline
//   All operands are internal nets with no driver here; they are driven and
//   observed hierarchically through the names listed in probes.svh.
module pd0
    import pd0_pkg::*;
#(
    parameter int DWIDTH = pd0_pkg::DWIDTH
) (
    input  logic clk_i,
    input  logic rst_ni
);

    logic              xor_op1;
    logic              xor_op2;
    logic              xor_res;

    logic [DWIDTH-1:0] alu_op1;
    logic [DWIDTH-1:0] alu_op2;
    logic [1:0]        alu_sel;
    logic [DWIDTH-1:0] alu_res;

    logic [DWIDTH-1:0] reg_inp;
    logic [DWIDTH-1:0] reg_out_q;

    logic [DWIDTH-1:0] tsp_op1;
    logic [DWIDTH-1:0] tsp_op2;
    logic [DWIDTH-1:0] tsp_res;

    assign xor_res = xor_op1 ^ xor_op2;

    // Add and subtract wrap at DWIDTH bits; carries are deliberately dropped.
    always_comb begin
        alu_res = '0;
        case (alu_sel_t'(alu_sel))
            ADD:     alu_res = alu_op1 + alu_op2;
            SUB:     alu_res = alu_op1 - alu_op2;
            AND:     alu_res = alu_op1 & alu_op2;
            OR:      alu_res = alu_op1 | alu_op2;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reg_out_q <= '0;
        end else begin
            reg_out_q <= reg_inp;
        end
    end

    three_stage_pipeline #(
        .DWIDTH (DWIDTH)
    ) u_tsp (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .op1_i  (tsp_op1),
        .op2_i  (tsp_op2),
        .res_o  (tsp_res)
    );

endmodule

// File: rtl/three_stage_pipeline.sv
// rtl/three_stage_pipeline.sv - register operands, register their sum, register again
//   clk_i  : rising-edge clock
//   rst_ni : asynchronous active-low clear of all stages
//   op1_i  : first addend, accepted every cycle
//   op2_i  : second addend, accepted every cycle
//   res_o  : sum of operands presented two edges earlier than the current edge
module three_stage_pipeline
    import pd0_pkg::*;
#(
    parameter int DWIDTH = pd0_pkg::DWIDTH
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DWIDTH-1:0] op1_i,
    input  logic [DWIDTH-1:0] op2_i,
    output logic [DWIDTH-1:0] res_o
);

    logic [DWIDTH-1:0] s1_op1_q, s1_op1_d;
    logic [DWIDTH-1:0] s1_op2_q, s1_op2_d;
    logic [DWIDTH-1:0] s2_sum_q, s2_sum_d;
    logic [DWIDTH-1:0] s3_res_q, s3_res_d;

    // The sum is formed from the registered operands, so it wraps at DWIDTH
    // bits and adds one edge of latency on its own.
    always_comb begin
        s1_op1_d = op1_i;
        s1_op2_d = op2_i;
        s2_sum_d = s1_op1_q + s1_op2_q;
        s3_res_d = s2_sum_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_op1_q <= '0;
            s1_op2_q <= '0;
            s2_sum_q <= '0;
            s3_res_q <= '0;
        end else begin
            s1_op1_q <= s1_op1_d;
            s1_op2_q <= s1_op2_d;
            s2_sum_q <= s2_sum_d;
            s3_res_q <= s3_res_d;
        end
    end

    assign res_o = s3_res_q;

endmodule

// File: rtl/design_wrapper.sv
// rtl/design_wrapper.sv - top level holding the single pd0 instance "core"
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
module design_wrapper
    import pd0_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic clk,
    input  logic reset
);

    pd0 #(
        .DWIDTH (DWIDTH)
    ) core (
        .clk_i  (clk),
        .rst_ni (reset)
    );

endmodule

// File: tb/probes.svh
// tb/probes.svh - core-relative net names for driving and observing pd0
`ifndef PROBES_SVH
`define PROBES_SVH

`define PROBE_ASSIGN_XOR_OP1 xor_op1
`define PROBE_ASSIGN_XOR_OP2 xor_op2
`define PROBE_ASSIGN_XOR_RES xor_res

`define PROBE_ALU_OP1 alu_op1
`define PROBE_ALU_OP2 alu_op2
`define PROBE_ALU_SEL alu_sel
`define PROBE_ALU_RES alu_res

`define ALU_SEL alu_sel
`define ALU_OP1 alu_op1
`define ALU_OP2 alu_op2

`define PROBE_REG_IN  reg_inp
`define PROBE_REG_INP reg_inp
`define PROBE_REG_OUT reg_out_q

`define PROBE_TSP_OP1 tsp_op1
`define PROBE_TSP_OP2 tsp_op2
`define PROBE_TSP_RES tsp_res

`endif

// File: tb/tb_design_wrapper.sv
// tb/tb_design_wrapper.sv - randomized and directed checks of design_wrapper against a behavioural model
`include "probes.svh"

module tb_design_wrapper;

    logic clk;
    logic reset;

    design_wrapper #(.DWIDTH(32)) dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 1'b0;

    // stimulus as known to the bench
    logic        s_xor_op1, s_xor_op2;
    logic [31:0] s_alu_op1, s_alu_op2;
    logic [1:0]  s_alu_sel;
    logic [31:0] s_reg_inp;
    logic [31:0] s_tsp_op1, s_tsp_op2;

    // model state: last captured register input, history of captured sums (newest first)
    logic [31:0] m_reg;
    logic [31:0] m_hist[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push();
        dut.core.`PROBE_ASSIGN_XOR_OP1 = s_xor_op1;
        dut.core.`PROBE_ASSIGN_XOR_OP2 = s_xor_op2;
        dut.core.`ALU_OP1              = s_alu_op1;
        dut.core.`ALU_OP2              = s_alu_op2;
        dut.core.`ALU_SEL              = s_alu_sel;
        dut.core.`PROBE_REG_INP        = s_reg_inp;
        dut.core.`PROBE_TSP_OP1        = s_tsp_op1;
        dut.core.`PROBE_TSP_OP2        = s_tsp_op2;
    endtask

    task automatic randomize_all(input bit nonzero);
        s_xor_op1 = 1'($urandom);
        s_xor_op2 = 1'($urandom);
        s_alu_op1 = $urandom;
        s_alu_op2 = $urandom;
        s_alu_sel = 2'($urandom);
        if (nonzero) begin
            s_reg_inp = $urandom_range(1000, 1);
            s_tsp_op1 = $urandom_range(1000, 1);
            s_tsp_op2 = $urandom_range(1000, 1);
        end else begin
            s_reg_inp = $urandom;
            s_tsp_op1 = $urandom;
            s_tsp_op2 = $urandom;
        end
        push();
    endtask

    // Inputs change 2 time units after each rising edge, well away from the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] alu_ref(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b);
        case (sel)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    // Reference: register output is the input seen at the last edge; pipeline
    // output is the sum seen two edges before the most recent one.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_reg = 32'd0;
            m_hist = '{32'd0, 32'd0, 32'd0};
        end else begin
            m_reg = s_reg_inp;
            m_hist.push_front(s_tsp_op1 + s_tsp_op2);
            void'(m_hist.pop_back());
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("xor_res", {31'd0, dut.core.`PROBE_ASSIGN_XOR_RES}, {31'd0, s_xor_op1 ^ s_xor_op2});
            chk("alu_res", dut.core.`PROBE_ALU_RES, alu_ref(s_alu_sel, s_alu_op1, s_alu_op2));
            chk("reg_out", dut.core.`PROBE_REG_OUT, m_reg);
            chk("tsp_res", dut.core.`PROBE_TSP_RES, m_hist[2]);
        end
    end

    logic [1:0]  xa [4];
    logic [1:0]  xe;
    logic [1:0]  asel [4];
    logic [31:0] aa [4];
    logic [31:0] ab [4];
    logic [31:0] ae [4];

    initial begin
        reset = 1'b0;
        s_xor_op1 = 1'b0; s_xor_op2 = 1'b0;
        s_alu_op1 = '0; s_alu_op2 = '0; s_alu_sel = '0;
        s_reg_inp = '0; s_tsp_op1 = '0; s_tsp_op2 = '0;
        m_reg = '0;
        m_hist = '{32'd0, 32'd0, 32'd0};
        push();

        // reset held for the first five cycles
        @(posedge clk);
        check_en = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_reg_out", dut.core.`PROBE_REG_OUT, 32'd0);
        chk("reset_tsp_res", dut.core.`PROBE_TSP_RES, 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        s_reg_inp = 32'd5;
        push();
        step();
        chk("reg_first_load", dut.core.`PROBE_REG_OUT, 32'd5);

        // xor truth table
        xa = '{2'b11, 2'b10, 2'b01, 2'b00};
        for (int i = 0; i < 4; i++) begin
            step();
            s_xor_op1 = xa[i][1];
            s_xor_op2 = xa[i][0];
            push();
            #1;
            xe = xa[i];
            chk("xor_table", {31'd0, dut.core.`PROBE_ASSIGN_XOR_RES}, {31'd0, (xe == 2'b10) || (xe == 2'b01)});
        end

        // alu corner cases
        asel = '{2'd0, 2'd1, 2'd2, 2'd3};
        aa   = '{32'hFFFF_FFFF, 32'h0, 32'h0000_F0F0, 32'h0000_F0F0};
        ab   = '{32'h1, 32'h1, 32'h0000_FF00, 32'h0000_FF00};
        ae   = '{32'h0, 32'hFFFF_FFFF, 32'h0000_F000, 32'h0000_FFF0};
        for (int i = 0; i < 4; i++) begin
            step();
            s_alu_sel = asel[i];
            s_alu_op1 = aa[i];
            s_alu_op2 = ab[i];
            push();
            #1;
            chk("alu_corner", dut.core.`PROBE_ALU_RES, ae[i]);
        end

        // pipeline latency: 3+4 before edge N
        step();
        s_tsp_op1 = 32'd3; s_tsp_op2 = 32'd4; push();
        step();
        s_tsp_op1 = 32'd0; s_tsp_op2 = 32'd0; push();
        @(negedge clk); chk("tsp_after_n",  dut.core.`PROBE_TSP_RES, 32'd0);
        step();
        @(negedge clk); chk("tsp_after_n1", dut.core.`PROBE_TSP_RES, 32'd0);
        step();
        @(negedge clk); chk("tsp_after_n2", dut.core.`PROBE_TSP_RES, 32'd7);
        step();
        @(negedge clk); chk("tsp_after_n3", dut.core.`PROBE_TSP_RES, 32'd0);

        // back-to-back sums 1,2,3
        for (int i = 1; i <= 3; i++) begin
            step();
            s_tsp_op1 = 32'(i); s_tsp_op2 = 32'd0; push();
        end
        step();
        s_tsp_op1 = 32'd0; push();
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("tsp_b2b", dut.core.`PROBE_TSP_RES, 32'(i));
            step();
        end

        // asynchronous reset with every stage holding nonzero data
        for (int i = 0; i < 4; i++) begin
            step();
            randomize_all(1'b1);
        end
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midreset_reg_out", dut.core.`PROBE_REG_OUT, 32'd0);
        chk("midreset_tsp_res", dut.core.`PROBE_TSP_RES, 32'd0);
        s_tsp_op1 = 32'd0; s_tsp_op2 = 32'd0; push();
        step();
        @(negedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("postreset_tsp_zero", dut.core.`PROBE_TSP_RES, 32'd0);
        end

        // randomized traffic, with one more reset dropped in at an odd time
        for (int i = 0; i < 400; i++) begin
            step();
            randomize_all(1'b0);
            if (i == 200) begin
                #1;
                reset = 1'b0;
                #3;
                reset = 1'b1;
            end
        end

        step();
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/design_wrapper.md
DESIGN_WRAPPER -- requirements
Module: design_wrapper

Interface
REQ-001 Parameter DWIDTH, default 32, datapath width of the ALU, register and pipeline probe nets.
REQ-002 Port clk  input  1  single clock; all sequential logic on rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 The module SHALL have no other ports; stimulus and observation use hierarchical access to instance "core" (module pd0) via probes.svh.
REQ-005 probes.svh SHALL define these macros as core-relative net names: PROBE_ASSIGN_XOR_OP1/OP2/RES; PROBE_ALU_OP1/OP2/SEL/RES; PROBE_REG_IN, PROBE_REG_INP, PROBE_REG_OUT; PROBE_TSP_OP1/OP2/RES.
REQ-006 probes.svh SHALL also define ALU_SEL, ALU_OP1, ALU_OP2 naming the same nets as the PROBE_ALU_* forms.
REQ-007 Probe input nets (xor op1/op2, alu op1/op2/sel, reg inp, tsp op1/op2) SHALL be declared logic in core with no internal driver.

Function
REQ-008 XOR: res = op1 XOR op2, 1 bit, combinational, zero latency.
REQ-009 ALU: 32-bit combinational; sel 00 = op1+op2, 01 = op1-op2, 10 = op1 AND op2, 11 = op1 OR op2.
REQ-010 ALU add/sub SHALL wrap modulo 2^32; no carry, overflow or flag outputs.
REQ-011 REG: out SHALL capture inp on every rising clk edge when reset is deasserted (one-cycle latency, no enable).
REQ-012 TSP stage 1 SHALL register op1 and op2 on every rising edge.
REQ-013 TSP stage 2 SHALL register the 32-bit wrapped sum of the stage-1 values.
REQ-014 TSP stage 3 SHALL register stage 2; res = stage-3 register.
REQ-015 TSP: inputs present before edge N SHALL appear on res after edge N+2 (three-edge latency); a new input is accepted every cycle; no handshake or stall.
REQ-016 All four sub-functions SHALL operate concurrently and independently.

Reset
REQ-017 reset low SHALL immediately clear REG out and all three TSP stage registers to 0, independent of clk.
REQ-018 Combinational outputs (XOR res, ALU res) SHALL have no reset and follow their inputs at all times.
REQ-019 Reset asserted mid-operation SHALL discard in-flight TSP data; after release res shows 0 until new data reaches stage 3.
REQ-020 The first rising edge after reset release SHALL load normally.
REQ-021 clockgen (companion) SHALL drive clk with a 10-time-unit period and hold reset low for the first 5 cycles, then high.

Structure
REQ-022 Package pd0_pkg SHALL hold DWIDTH and typedef alu_sel_t (2-bit enum ADD, SUB, AND, OR).
REQ-023 design_wrapper SHALL contain only instance core of pd0; pd0 SHALL contain the four functions.
REQ-024 The three-stage pipeline SHALL be a separate sub-module, three_stage_pipeline, instantiated in pd0.

Verification
REQ-025 XOR: (1,1) -> 0; (1,0) -> 1; (0,1) -> 1; (0,0) -> 0.
REQ-026 ALU: ADD 0xFFFFFFFF+1 -> 0x00000000; SUB 0-1 -> 0xFFFFFFFF; AND 0xF0F0&0xFF00 -> 0xF000; OR 0xF0F0|0xFF00 -> 0xFFF0.
REQ-027 REG: reset low -> out 0 immediately; release, inp=5 -> out=5 after next rising edge.
REQ-028 TSP: op1=3, op2=4 before edge N, inputs then 0 -> res=7 after edge N+2, res=0 after edge N+3; res 0 before N+2.
REQ-029 TSP back-to-back: sums 1,2,3 presented on consecutive cycles -> res shows 1,2,3 on consecutive cycles.
REQ-030 Reset mid-pipeline: reset low with nonzero data in all stages -> res and REG out 0 before next clk edge; 0 persists until new data arrives.
